fetch_pc_ifid: RTL and testbench

Fetch-stage control block for the RISC-V pipeline.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from downstream hazard/EX logic.
- Sits between the hazard unit/EX stage and the decode stage. Instruction memory is combinational read, word-indexed from the address.

---
 rtl/fetch_pc_ifid.sv | 95 +++++++++
 tb/tb_fetch_pc_ifid.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ifid.sv
// fetch_pc_ifid: fetch-stage control for the RISC-V pipeline.
// Owns the program counter, drives the combinational instruction-memory
// address and captures the returned word into the IF/ID register.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt and
// perf_bubble_cnt event counters.
//
// Handshake: there is no valid/ready pair. The downstream hazard unit holds
// the stage with stall, squashes IF/ID with flush, and steers the PC with
// redirect. id_valid marks whether IF/ID holds a real instruction.
module fetch_pc_ifid #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt,
`endif
   output logic        id_valid
);

   // IF/ID slot state: BUBBLE holds the NOP, VALID holds a fetched word.
   // The state register is exported directly as id_valid.
   localparam logic [0:0] ST_BUBBLE = 1'b0;
   localparam logic [0:0] ST_VALID  = 1'b1;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [0:0]  id_state;
   logic        load_bubble;
   logic        load_normal;

   // Redirect always squashes the wrong-path word; stall only matters
   // when neither flush nor redirect is present.
   assign pc_plus4    = pc + 32'd4;
   assign load_bubble = flush | redirect;
   assign load_normal = ~load_bubble & ~stall;
   assign imem_addr   = pc;
   assign id_valid    = id_state[0];

   // Program counter: redirect beats stall; low target bits are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
         pc <= pc_plus4;
      end
   end

   // IF/ID register: bubble on flush/redirect, hold on stall, else load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_instr    <= NOP_INSTR;
         id_pc       <= 32'd0;
         id_pc_plus4 <= 32'd0;
         id_state    <= ST_BUBBLE;
      end else if (load_bubble) begin
         id_instr    <= NOP_INSTR;
         id_pc       <= 32'd0;
         id_pc_plus4 <= 32'd0;
         id_state    <= ST_BUBBLE;
      end else if (load_normal) begin
         id_instr    <= imem_instr;
         id_pc       <= pc;
         id_pc_plus4 <= pc_plus4;
         id_state    <= ST_VALID;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Event counters: one count per normal load or per bubble load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_cnt  <= 32'd0;
         perf_bubble_cnt <= 32'd0;
      end else begin
         if (load_normal) perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
         if (load_bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// tb_fetch_pc_ifid: scoreboard bench for fetch_pc_ifid.
// A driver applies stall/flush/redirect per cycle, updates a reference model
// of the stage and pushes the expected post-edge view into exp_q; a monitor
// on the falling edge pops and compares against the DUT outputs.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_pc_ifid;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int W = 129;  // {addr, instr, pc, pc4, valid}

   // clock / reset / DUT signals
   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_idpc;
   logic [31:0] m_idpc4;
   logic        m_valid;
   logic [31:0] m_fetch_cnt;
   logic [31:0] m_bubble_cnt;

   fetch_pc_ifid #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem_addr(imem_addr),
      .imem_instr(imem_instr),
      .id_instr(id_instr),
      .id_pc(id_pc),
      .id_pc_plus4(id_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_bubble_cnt(perf_bubble_cnt),
`endif
      .id_valid(id_valid)
   );

   // clock block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // instruction memory contents: fixed program words, hashed elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0000_0093;
         32'h0000_0004: mem_word = 32'h0010_0113;
         32'h0000_0008: mem_word = 32'h0020_8193;
         default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   assign imem_instr = mem_word(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp();
      exp_q.push_back({m_pc, m_instr, m_idpc, m_idpc4, m_valid});
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;  m_instr = NOP_INSTR;
      m_idpc = 32'd0;   m_idpc4 = 32'd0;  m_valid = 1'b0;
      m_fetch_cnt = 32'd0;  m_bubble_cnt = 32'd0;
   endtask

   // hold reset for two edges, checking the reset view after each
   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         push_exp();
         #2;
      end
      reset = 1'b0;
   endtask

   // one clock of stimulus; the model follows the stage rules directly
   task automatic cycle(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
      logic [31:0] n_pc;
      logic [31:0] fetched;
      stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
      fetched = mem_word(m_pc);
      if (rd)      n_pc = rpc & 32'hFFFF_FFFC;
      else if (st) n_pc = m_pc;
      else         n_pc = m_pc + 32'd4;
      @(posedge clk);
      if (fl || rd) begin
         m_instr = NOP_INSTR; m_idpc = 32'd0; m_idpc4 = 32'd0; m_valid = 1'b0;
         m_bubble_cnt = m_bubble_cnt + 32'd1;
      end else if (!st) begin
         m_instr = fetched; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4; m_valid = 1'b1;
         m_fetch_cnt = m_fetch_cnt + 32'd1;
      end
      m_pc = n_pc;
      push_exp();
      #2;
   endtask

   // monitor: compare each post-edge expectation on the falling edge
   logic [W-1:0] e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("imem_addr",   imem_addr,          e[128:97]);
         chk("id_instr",    id_instr,           e[96:65]);
         chk("id_pc",       id_pc,              e[64:33]);
         chk("id_pc_plus4", id_pc_plus4,        e[32:1]);
         chk("id_valid",    {31'd0, id_valid},  {31'd0, e[0]});
      end
   end

   initial begin
      do_reset();
      // straight-line fetch 0x0, 0x4
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      // pc = 0x8: two stall cycles, then release loads 0x8 word
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      // pc = 0x10: redirect to 0x103 -> 0x100, then load its word
      cycle(0, 0, 1, 32'h0000_0103);
      cycle(0, 0, 0, 0);
      // stall + redirect together
      cycle(1, 0, 1, 32'h0000_0040);
      cycle(0, 0, 0, 0);
      // flush alone advances pc; stall + flush holds pc with a bubble
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      // wrap at the top of the address space
      cycle(0, 0, 1, 32'hFFFF_FFFE);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0), $urandom);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt_rand",  perf_fetch_cnt,  m_fetch_cnt);
      chk("perf_bubble_cnt_rand", perf_bubble_cnt, m_bubble_cnt);
`endif
      // asynchronous reset mid-cycle takes effect before the next edge
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("async_imem_addr", imem_addr, RESET_PC);
      chk("async_id_valid",  {31'd0, id_valid}, 32'd0);
      chk("async_id_instr",  id_instr, NOP_INSTR);
      do_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt",  perf_fetch_cnt,  32'd5);
      chk("perf_bubble_cnt", perf_bubble_cnt, 32'd2);
`endif
      @(negedge clk);
      #1;
      chk("exp_q_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
